// File: rtl/inv_sub_bytes_serial_pkg.sv
// Shared AES definitions for the decrypt datapath.
//   AES_BLOCK_W / AES_BYTE_W / AES_NUM_BYTES : block geometry
//   sub_state_e : InvSubBytes sequencer states
//   byte_msb()  : byte i of a block lives in bits [byte_msb(i) -: 8],
//                 byte 0 in the top byte of the block.
package inv_sub_bytes_serial_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    function automatic int byte_msb(input int i);
        return AES_BLOCK_W - 1 - AES_BYTE_W * i;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_serial_if.sv
// Valid/ready bus for one 128-bit AES state in and one out.
//   in_valid/in_ready/in_state    : upstream (InvShiftRows) side
//   out_valid/out_ready/out_state : downstream (AddRoundKey) side
//   modport master : the environment around the stage
//   modport slave  : the InvSubBytes stage itself
interface inv_sub_bytes_serial_if;
    import inv_sub_bytes_serial_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_state;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );

endinterface

// File: rtl/inv_sub_bytes_serial_sbox.sv
// AES inverse S-box, purely combinational.
//   a : input byte
//   c : InvSbox(a)
module inv_sub_bytes_serial_sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    // Entry 0 is the leftmost byte, so entry x sits at bits [(255-x)*8 +: 8],
    // and (255-x) is simply ~x.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] sel;

    assign sel = {~a, 3'b000};
    assign c   = INV_SBOX[sel +: 8];

endmodule

// File: rtl/inv_sub_bytes_serial.sv
// Multi-cycle InvSubBytes stage: accepts one state, substitutes LANES bytes
// per cycle through LANES inverse S-boxes, then holds the result until taken.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : slave side of inv_sub_bytes_serial_if (in/out valid/ready/state)
//   blk_count : completed-block counter, only when INV_SUB_BYTES_STATUS_EN
//               is defined (wraps at 16 bits)
//   LANES     : bytes per cycle, one of 1, 2, 4, 8, 16
//
// state | meaning
// IDLE  | ready for a new state
// SUB   | substituting beat beat_q
// DONE  | result valid on out_state, waiting for out_ready
module inv_sub_bytes_serial
    import inv_sub_bytes_serial_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic clk,
    input  logic rst,
    inv_sub_bytes_serial_if.slave bus
`ifdef INV_SUB_BYTES_STATUS_EN
    ,
    output logic [15:0] blk_count
`endif
);

    localparam int BEATS  = AES_NUM_BYTES / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    sub_state_e              fsm_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [AES_BLOCK_W-1:0]  state_q;
    logic [AES_BLOCK_W-1:0]  sub_next;
    logic                    out_valid_q;
    logic [AES_BYTE_W-1:0]   lane_out [LANES];

    // Lane k serves byte beat*LANES+k; its source byte is picked by beat_q.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BEATS-1:0][AES_BYTE_W-1:0] cand;
        logic [AES_BYTE_W-1:0]            lane_in;

        for (genvar b = 0; b < BEATS; b++) begin : g_cand
            assign cand[b] = state_q[byte_msb(b * LANES + k) -: AES_BYTE_W];
        end

        if (BEATS == 1) begin : g_one
            assign lane_in = cand[0];
        end else begin : g_mux
            assign lane_in = cand[beat_q];
        end

        inv_sub_bytes_serial_sbox u_sbox (
            .a (lane_in),
            .c (lane_out[k])
        );
    end

    // Only the bytes of the current beat change; everything else holds.
    for (genvar i = 0; i < AES_NUM_BYTES; i++) begin : g_byte
        localparam int B = i / LANES;
        localparam int K = i % LANES;
        assign sub_next[byte_msb(i) -: AES_BYTE_W] =
            (beat_q == BEAT_W'(B)) ? lane_out[K] : state_q[byte_msb(i) -: AES_BYTE_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            beat_q      <= '0;
            state_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef INV_SUB_BYTES_STATUS_EN
            blk_count   <= '0;
`endif
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= bus.in_state;
                        beat_q  <= '0;
                        fsm_q   <= SUB;
                    end
                end
                SUB: begin
                    state_q <= sub_next;
                    beat_q  <= beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
`ifdef INV_SUB_BYTES_STATUS_EN
                        blk_count   <= blk_count + 16'd1;
`endif
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rst so nothing is offered to upstream while reset is held.
    assign bus.in_ready  = (fsm_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = state_q;

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
module tb_inv_sub_bytes_serial;
    import inv_sub_bytes_serial_pkg::*;

    localparam logic [127:0] V1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] EXP1 = 128'h52096ad53036a538bf40a39e81f3d7fb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_sub_bytes_serial_if bus ();
`ifdef INV_SUB_BYTES_STATUS_EN
    logic [15:0] blk_count;
`endif

    inv_sub_bytes_serial #(.LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef INV_SUB_BYTES_STATUS_EN
        ,
        .blk_count (blk_count)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: forward S-box from GF(2^8), inverted
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) b = 8'(y);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [15:0][7:0] v, r;
        v = s;
        for (int i = 0; i < 16; i++) r[4'(i)] = inv_tab[v[4'(i)]];
        return r;
    endfunction

    // ---------------- checkers
    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: push on acceptance, pop on output handshake
    typedef struct {
        logic [127:0] exp;
        int           acc;
    } exp_t;

    exp_t sb [$];
    int   acc_log [$];
    bit   lat_seen = 1'b0;
    int   hs_since_rst = 0;

    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            sb.push_back('{model(bus.in_state), cyc + 1});
            acc_log.push_back(cyc + 1);
        end
        if (!rst && bus.out_valid) begin
            checks++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_output observed=%h expected=no_output", bus.out_state);
            end
            if (sb.size() != 0) begin
                if (!lat_seen) begin
                    chkint("latency", cyc - sb[0].acc, 4);
                    lat_seen = 1'b1;
                end
                if (bus.out_ready) begin
                    chk128("out_state", bus.out_state, sb[0].exp);
                    void'(sb.pop_front());
                    lat_seen = 1'b0;
                    hs_since_rst++;
                end
            end
        end
    end

    // ---------------- LANES sweep instances
    logic         sw_valid;
    logic [127:0] sw_state;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        inv_sub_bytes_serial_if sif ();
        int           lat = -1;
        int           cnt = 0;
        bit           armed = 1'b0;
        bit           done = 1'b0;
        logic [127:0] res = '0;
`ifdef INV_SUB_BYTES_STATUS_EN
        logic [15:0]  sw_blk;
`endif
        assign sif.in_valid  = sw_valid;
        assign sif.in_state  = sw_state;
        assign sif.out_ready = 1'b1;

        inv_sub_bytes_serial #(.LANES(L)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (sif)
`ifdef INV_SUB_BYTES_STATUS_EN
            ,
            .blk_count (sw_blk)
`endif
        );

        always @(negedge clk) begin
            if (!armed && sif.in_valid && sif.in_ready) begin
                armed = 1'b1;
                cnt   = -1;
            end else if (armed && !done) begin
                cnt++;
                if (sif.out_valid) begin
                    done = 1'b1;
                    lat  = cnt;
                    res  = sif.out_state;
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic send(input logic [127:0] s);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_state = s;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = bus.in_ready;
        end
        chkint("accept_timeout", int'(got), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = bus.out_valid;
        end
        chkint(tag, int'(got), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chkint("drain_timeout", sb.size(), 0);
    endtask

    // ---------------- directed sequence
    initial begin
        logic [127:0] exp_s, r;
        int a1, a2, nacc, rises;

        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b1;
        sw_valid      = 1'b0;
        sw_state      = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chkint("rst_in_ready", int'(bus.in_ready), 0);
        chkint("rst_out_valid", int'(bus.out_valid), 0);
        chk128("rst_out_state", bus.out_state, '0);
`ifdef INV_SUB_BYTES_STATUS_EN
        chkint("rst_blk_count", int'(blk_count), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chkint("in_ready_after_rst", int'(bus.in_ready), 1);

        // known-answer vector
        send(V1);
        wait_out("kat_timeout");
        chk128("kat_out_state", bus.out_state, EXP1);
        drain();

        // back-to-back with in_valid held high
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_state = {16{8'h63}};
        nacc = acc_log.size();
        for (int n = 0; n < 50 && acc_log.size() == nacc; n++) @(negedge clk);
        @(posedge clk); #1;
        bus.in_state = {16{8'h7c}};
        for (int n = 0; n < 50 && acc_log.size() == nacc + 1; n++) @(negedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chkint("b2b_accepts", acc_log.size() - nacc, 2);
        a1 = acc_log[nacc];
        a2 = acc_log[acc_log.size() - 1];
        chkint("b2b_period", a2 - a1, 6);
        chk128("b2b_model_63", model({16{8'h63}}), {16{8'h00}});
        drain();

        // output stall with in_valid/in_state wiggling
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        r = {$urandom, $urandom, $urandom, $urandom};
        exp_s = model(r);
        send(r);
        wait_out("stall_timeout");
        nacc = acc_log.size();
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            bus.in_valid = ~bus.in_valid;
            bus.in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk128("stall_out_state", bus.out_state, exp_s);
            chkint("stall_in_ready", int'(bus.in_ready), 0);
            chkint("stall_out_valid", int'(bus.out_valid), 1);
        end
        chkint("stall_no_accept", acc_log.size() - nacc, 0);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // reset during the second SUB cycle of a 0xff block
        send({16{8'hff}});
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        lat_seen = 1'b0;
        hs_since_rst = 0;
        @(negedge clk);
        chkint("midrst_in_ready", int'(bus.in_ready), 0);
        chkint("midrst_out_valid", int'(bus.out_valid), 0);
        chk128("midrst_out_state", bus.out_state, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        rises = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.out_valid) rises++;
        end
        chkint("midrst_no_output", rises, 0);
        send({16{8'h00}});
        wait_out("post_rst_timeout");
        chk128("post_rst_out_state", bus.out_state, {16{8'h52}});
        drain();

        // a few random blocks
        for (int n = 0; n < 4; n++) begin
            send({$urandom, $urandom, $urandom, $urandom});
            drain();
        end

`ifdef INV_SUB_BYTES_STATUS_EN
        @(negedge clk);
        chkint("blk_count", int'(blk_count), hs_since_rst);
`endif

        // LANES sweep: same vector through 1/2/8/16-lane builds
        @(posedge clk); #1;
        sw_state = V1;
        sw_valid = 1'b1;
        @(posedge clk); #1;
        sw_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chkint("sweep_l1_latency", g_sw[0].lat, 16);
        chkint("sweep_l2_latency", g_sw[1].lat, 8);
        chkint("sweep_l8_latency", g_sw[2].lat, 2);
        chkint("sweep_l16_latency", g_sw[3].lat, 1);
        chk128("sweep_l1_out_state", g_sw[0].res, EXP1);
        chk128("sweep_l2_out_state", g_sw[1].res, EXP1);
        chk128("sweep_l8_out_state", g_sw[2].res, EXP1);
        chk128("sweep_l16_out_state", g_sw[3].res, EXP1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
